// File: rtl/pipe_pkg.sv
// Shared types and constants for the 3-stage pipeline sequencer.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    ERR      = 2'd3
  } pseq_state_t;

  localparam logic FWD_RF = 1'b0;
  localparam logic FWD_MW = 1'b1;

  localparam int REG_AW = 5;

endpackage

// File: rtl/hazard_detect.sv
// RAW hazard compare between the DE source registers and the MW destination.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic              i_valid_de,
  input  logic              i_rf_en_mw,
  input  logic [REG_AW-1:0] i_rd_mw,
  input  logic [REG_AW-1:0] i_rs1_de,
  input  logic [REG_AW-1:0] i_rs2_de,
  output logic              o_hit_a,
  output logic              o_hit_b
);

  logic w_mw_writes;

  // x0 is hard-wired to zero, so a write to it never creates a hazard
  assign w_mw_writes = i_rf_en_mw & (i_rd_mw != '0) & i_valid_de;
  assign o_hit_a     = w_mw_writes & (i_rd_mw == i_rs1_de);
  assign o_hit_b     = w_mw_writes & (i_rd_mw == i_rs2_de);

endmodule

// File: rtl/pipe_sequencer.sv
// Stall/flush/bubble/forwarding sequencer for the IF-DE-MW core.
// Build option: define PIPE_SEQ_FWD_EN to forward MW results instead of stalling.
module pipe_sequencer
  import pipe_pkg::*;
#(
  parameter int FLUSH_CYC   = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_de,
  input  logic              sel_pc_de,
  input  logic [REG_AW-1:0] rs1_de,
  input  logic [REG_AW-1:0] rs2_de,
  input  logic [REG_AW-1:0] rd_mw,
  input  logic              rf_en_mw,
  input  logic              mem_req_mw,
  input  logic              dmem_ack,
  output logic              stall_if,
  output logic              stall_de,
  output logic              flush_de,
  output logic              bubble_mw,
  output logic              stall_mw,
  output logic              dmem_req,
  output logic              fwd_a,
  output logic              fwd_b,
  output logic              timeout_err
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [1:0]  FL_REM  = 2'(FLUSH_CYC - 1);

  pseq_state_t r_state;
  logic [15:0] r_wait_cnt;
  logic [1:0]  r_flush_rem;
  logic        r_flush_pend;

  logic w_hit_a, w_hit_b;
  logic w_jump, w_mem_stall, w_raw_stall, w_fwd_ok;

  hazard_detect u_hazard (
    .i_valid_de (valid_de),
    .i_rf_en_mw (rf_en_mw),
    .i_rd_mw    (rd_mw),
    .i_rs1_de   (rs1_de),
    .i_rs2_de   (rs2_de),
    .o_hit_a    (w_hit_a),
    .o_hit_b    (w_hit_b)
  );

  assign w_jump      = valid_de & sel_pc_de;
  assign w_mem_stall = mem_req_mw & ~dmem_ack;
  assign w_fwd_ok    = ~rst & ~stall_mw;

`ifdef PIPE_SEQ_FWD_EN
  assign w_raw_stall = 1'b0;
  assign fwd_a       = (w_fwd_ok & w_hit_a) ? FWD_MW : FWD_RF;
  assign fwd_b       = (w_fwd_ok & w_hit_b) ? FWD_MW : FWD_RF;
`else
  assign w_raw_stall = w_hit_a | w_hit_b;
  assign fwd_a       = FWD_RF;
  assign fwd_b       = FWD_RF;
  logic w_unused_fwd_ok;
  assign w_unused_fwd_ok = w_fwd_ok;
`endif

  // Controls: combinational from state and inputs, priority ERR > mem > jump > RAW
  always_comb begin
    stall_if    = 1'b0;
    stall_de    = 1'b0;
    flush_de    = 1'b0;
    bubble_mw   = 1'b0;
    stall_mw    = 1'b0;
    dmem_req    = 1'b0;
    timeout_err = 1'b0;
    if (rst) begin
      flush_de  = 1'b1;
      bubble_mw = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          dmem_req = mem_req_mw;
          if (w_mem_stall) begin
            stall_if = 1'b1;
            stall_de = 1'b1;
            stall_mw = 1'b1;
          end else if (w_jump) begin
            flush_de = 1'b1;
          end else if (w_raw_stall) begin
            stall_if  = 1'b1;
            stall_de  = 1'b1;
            bubble_mw = 1'b1;
          end
        end
        MEM_WAIT: begin
          dmem_req = mem_req_mw;
          if (!dmem_ack) begin
            stall_if = 1'b1;
            stall_de = 1'b1;
            stall_mw = 1'b1;
          end else if (r_flush_pend || w_jump) begin
            flush_de = 1'b1;
          end
        end
        FLUSH: begin
          dmem_req = mem_req_mw;
          if (w_mem_stall) begin
            stall_if = 1'b1;
            stall_de = 1'b1;
            stall_mw = 1'b1;
          end else begin
            flush_de = 1'b1;
          end
        end
        ERR: begin
          stall_if    = 1'b1;
          stall_de    = 1'b1;
          stall_mw    = 1'b1;
          timeout_err = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // r_flush_rem counts flush cycles still owed, including the current FLUSH cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_wait_cnt   <= '0;
      r_flush_rem  <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mem_stall) begin
            r_wait_cnt <= 16'd1;
            r_state    <= (TO_LAST == 16'd0) ? ERR : MEM_WAIT;
          end else if (w_jump && FLUSH_CYC > 1) begin
            r_flush_rem <= FL_REM;
            r_state     <= FLUSH;
          end
        end
        MEM_WAIT: begin
          if (dmem_ack) begin
            r_wait_cnt <= '0;
            if (r_flush_pend) begin
              r_flush_pend <= 1'b0;
              if (r_flush_rem == 2'd1) begin
                r_flush_rem <= '0;
                r_state     <= RUN;
              end else begin
                r_flush_rem <= r_flush_rem - 2'd1;
                r_state     <= FLUSH;
              end
            end else if (w_jump && FLUSH_CYC > 1) begin
              r_flush_rem <= FL_REM;
              r_state     <= FLUSH;
            end else begin
              r_state <= RUN;
            end
          end else if (r_wait_cnt == TO_LAST) begin
            r_state <= ERR;
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
        end
        FLUSH: begin
          if (w_mem_stall) begin
            r_flush_pend <= 1'b1;
            r_wait_cnt   <= 16'd1;
            r_state      <= (TO_LAST == 16'd0) ? ERR : MEM_WAIT;
          end else if (r_flush_rem == 2'd1) begin
            r_flush_rem <= '0;
            r_state     <= RUN;
          end else begin
            r_flush_rem <= r_flush_rem - 2'd1;
          end
        end
        ERR: r_state <= ERR;
        default: r_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed, table-driven bench for pipe_sequencer (FLUSH_CYC=2, TIMEOUT_CYC=4).
module tb_pipe_sequencer;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst, valid_de, sel_pc_de, rf_en_mw, mem_req_mw, dmem_ack;
  logic [4:0] rs1_de, rs2_de, rd_mw;
  logic stall_if, stall_de, flush_de, bubble_mw, stall_mw, dmem_req, fwd_a, fwd_b, timeout_err;

  always #5 clk = ~clk;

  pipe_sequencer #(.FLUSH_CYC(2), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .valid_de(valid_de), .sel_pc_de(sel_pc_de),
    .rs1_de(rs1_de), .rs2_de(rs2_de), .rd_mw(rd_mw), .rf_en_mw(rf_en_mw),
    .mem_req_mw(mem_req_mw), .dmem_ack(dmem_ack),
    .stall_if(stall_if), .stall_de(stall_de), .flush_de(flush_de),
    .bubble_mw(bubble_mw), .stall_mw(stall_mw), .dmem_req(dmem_req),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .timeout_err(timeout_err)
  );

  // Output vector order: stall_if stall_de flush_de bubble_mw stall_mw dmem_req fwd_a fwd_b timeout_err
  localparam logic [8:0] E_IDLE  = 9'b000000000;
  localparam logic [8:0] E_RST   = 9'b001100000;
  localparam logic [8:0] E_REQ   = 9'b000001000;
  localparam logic [8:0] E_WAIT  = 9'b110011000;
  localparam logic [8:0] E_FL    = 9'b001000000;
  localparam logic [8:0] E_FLREQ = 9'b001001000;
  localparam logic [8:0] E_ERR   = 9'b110010001;
`ifdef PIPE_SEQ_FWD_EN
  localparam logic [8:0] E_HITA   = 9'b000000100;
  localparam logic [8:0] E_HITB   = 9'b000000010;
  localparam logic [8:0] E_ACKHIT = 9'b000001100;
`else
  localparam logic [8:0] E_HITA   = 9'b110100000;
  localparam logic [8:0] E_HITB   = 9'b110100000;
  localparam logic [8:0] E_ACKHIT = 9'b000001000;
`endif

  typedef struct {
    logic       rst, valid, sel;
    logic [4:0] rs1, rs2, rd;
    logic       rf_en, req, ack;
    logic [8:0] exp;
    string      name;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic r, input logic v, input logic s,
                              input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                              input logic we, input logic rq, input logic ak,
                              input logic [8:0] e, input string n);
    vec_t t;
    t.rst = r; t.valid = v; t.sel = s; t.rs1 = a; t.rs2 = b; t.rd = d;
    t.rf_en = we; t.req = rq; t.ack = ak; t.exp = e; t.name = n;
    return t;
  endfunction

  // Drive one cycle of inputs, check the settled outputs, then advance past the edge
  task automatic run(input vec_t v);
    logic [8:0] got;
    rst = v.rst; valid_de = v.valid; sel_pc_de = v.sel;
    rs1_de = v.rs1; rs2_de = v.rs2; rd_mw = v.rd;
    rf_en_mw = v.rf_en; mem_req_mw = v.req; dmem_ack = v.ack;
    #2;
    got = {stall_if, stall_de, flush_de, bubble_mw, stall_mw, dmem_req, fwd_a, fwd_b, timeout_err};
    checks++;
    if (got !== v.exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", v.name, got, v.exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset, idle, zero-wait access
    vq.push_back(mk(1,0,0, 0,0,0, 0,0,0, E_RST,  "reset"));
    vq.push_back(mk(0,0,0, 0,0,0, 0,0,0, E_IDLE, "idle_after_reset"));
    vq.push_back(mk(0,0,0, 0,0,0, 0,1,1, E_REQ,  "zero_wait"));
    vq.push_back(mk(0,0,0, 0,0,0, 0,0,0, E_IDLE, "zero_wait_stays_run"));
    // three-cycle wait
    vq.push_back(mk(0,0,0, 0,0,0, 0,1,0, E_WAIT, "wait_c1"));
    vq.push_back(mk(0,0,0, 0,0,0, 0,1,0, E_WAIT, "wait_c2"));
    vq.push_back(mk(0,0,0, 0,0,0, 0,1,1, E_REQ,  "wait_ack"));
    vq.push_back(mk(0,0,0, 0,0,0, 0,0,0, E_IDLE, "wait_done"));
    // jump: two flush cycles
    vq.push_back(mk(0,1,1, 0,0,0, 0,0,0, E_FL,   "jump_f1"));
    vq.push_back(mk(0,0,0, 0,0,0, 0,0,0, E_FL,   "jump_f2"));
    vq.push_back(mk(0,0,0, 0,0,0, 0,0,0, E_IDLE, "jump_done"));
    // jump held in DE during a memory wait
    vq.push_back(mk(0,1,1, 0,0,0, 0,1,0, E_WAIT,  "jwait_c1"));
    vq.push_back(mk(0,1,1, 0,0,0, 0,1,0, E_WAIT,  "jwait_c2"));
    vq.push_back(mk(0,1,1, 0,0,0, 0,1,1, E_FLREQ, "jwait_ack_flush"));
    vq.push_back(mk(0,0,0, 0,0,0, 0,0,0, E_FL,    "jwait_f2"));
    vq.push_back(mk(0,0,0, 0,0,0, 0,0,0, E_IDLE,  "jwait_done"));
    // memory request interrupts a flush; remaining flush follows the ack
    vq.push_back(mk(0,1,1, 0,0,0, 0,0,0, E_FL,    "fint_f1"));
    vq.push_back(mk(0,0,0, 0,0,0, 0,1,0, E_WAIT,  "fint_req"));
    vq.push_back(mk(0,0,0, 0,0,0, 0,1,1, E_FLREQ, "fint_ack_f2"));
    vq.push_back(mk(0,0,0, 0,0,0, 0,0,0, E_IDLE,  "fint_done"));
    // data hazards
    vq.push_back(mk(0,1,0, 5,3,5, 1,0,0, E_HITA,   "hit_rs1"));
    vq.push_back(mk(0,1,0, 5,3,5, 0,0,0, E_IDLE,   "hit_cleared"));
    vq.push_back(mk(0,1,0, 0,0,0, 1,0,0, E_IDLE,   "rd_zero_no_hit"));
    vq.push_back(mk(0,1,0, 1,7,7, 1,0,0, E_HITB,   "hit_rs2"));
    vq.push_back(mk(0,1,0, 5,3,5, 1,1,0, E_WAIT,   "hit_gated_in_wait"));
    vq.push_back(mk(0,1,0, 5,3,5, 1,1,1, E_ACKHIT, "hit_on_ack"));
    vq.push_back(mk(0,0,0, 0,0,0, 0,0,0, E_IDLE,   "hit_done"));
    // ack on the last allowed wait cycle wins over timeout
    vq.push_back(mk(0,0,0, 0,0,0, 0,1,0, E_WAIT, "late_c0"));
    vq.push_back(mk(0,0,0, 0,0,0, 0,1,0, E_WAIT, "late_c1"));
    vq.push_back(mk(0,0,0, 0,0,0, 0,1,0, E_WAIT, "late_c2"));
    vq.push_back(mk(0,0,0, 0,0,0, 0,1,1, E_REQ,  "late_ack_c3"));
    vq.push_back(mk(0,0,0, 0,0,0, 0,0,0, E_IDLE, "late_back_in_run"));

    foreach (vq[i]) run(vq[i]);

    // timeout: four unacked wait cycles, then sticky ERR until reset
    for (int c = 0; c < 4; c++) run(mk(0,0,0, 0,0,0, 0,1,0, E_WAIT, "to_wait"));
    run(mk(0,0,0, 0,0,0, 0,1,0, E_ERR, "to_err"));
    run(mk(0,0,0, 0,0,0, 0,1,1, E_ERR, "to_err_ignores_ack"));
    run(mk(0,1,1, 0,0,0, 0,0,0, E_ERR, "to_err_ignores_jump"));
    run(mk(1,0,0, 0,0,0, 0,1,0, E_RST, "to_reset"));
    run(mk(0,0,0, 0,0,0, 0,0,0, E_IDLE, "to_cleared"));

    // reset mid-wait leaves no residue
    run(mk(0,0,0, 0,0,0, 0,1,0, E_WAIT, "rw_wait"));
    run(mk(1,0,0, 0,0,0, 0,1,0, E_RST,  "rw_reset"));
    run(mk(0,0,0, 0,0,0, 0,1,1, E_REQ,  "rw_zero_wait"));

    // reset mid-flush leaves no residue
    run(mk(0,1,1, 0,0,0, 0,0,0, E_FL,   "rf_f1"));
    run(mk(1,0,0, 0,0,0, 0,0,0, E_RST,  "rf_reset"));
    run(mk(0,0,0, 0,0,0, 0,0,0, E_IDLE, "rf_no_flush"));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
